// File: rtl/out_compare_pkg.sv
// Shared types and helpers for the golden-vs-netlist output compare checker.
package out_compare_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CMP  = 2'd2
  } state_t;

  localparam int SETTLE_MAX = 255;
  localparam int SAT_FN_W   = 32;

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [SAT_FN_W-1:0] sat_inc(input logic [SAT_FN_W-1:0] v,
                                                  input int w);
    logic [SAT_FN_W-1:0] cap;
    cap = (w >= SAT_FN_W) ? '1 : ((32'd1 << w) - 32'd1);
    return (v == cap) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/out_compare_checker_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter
  import out_compare_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= W'(sat_inc(SAT_FN_W'(count), W));
    end
  end

endmodule

// File: rtl/out_compare_checker.sv
// Golden-vs-post-route output checker: each accepted strobe waits SETTLE cycles,
// then compares the masked output words and updates counters / first-fail capture.
module out_compare_checker
  import out_compare_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stim_valid,
  output logic             stim_ready,
  input  logic [WIDTH-1:0] golden_out,
  input  logic [WIDTH-1:0] netlist_out,
  input  logic [WIDTH-1:0] cmp_mask,
  output logic             cmp_done,
  output logic             cmp_match,
  output logic [CNT_W-1:0] compare_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             first_fail_valid,
  output logic [WIDTH-1:0] first_fail_golden,
  output logic [WIDTH-1:0] first_fail_netlist,
  output logic [CNT_W-1:0] first_fail_index,
  output logic             overrun,
  output logic             pass,
  output logic [1:0]       dbg_state
);

  localparam int SETTLE_C = (SETTLE < 1) ? 1 :
                            ((SETTLE > SETTLE_MAX) ? SETTLE_MAX : SETTLE);

  // Handshake: a stimulus is accepted on a rising edge where stim_valid && stim_ready;
  // stim_valid while stim_ready is low is not queued, it only raises the sticky overrun.

  state_t     state;
  logic [7:0] wait_cnt;
  logic       match_now;
  logic       cmp_inc;
  logic       mis_inc;

  assign stim_ready = (state == IDLE);
  assign dbg_state  = state;
  assign match_now  = (((golden_out ^ netlist_out) & cmp_mask) == '0);
  assign cmp_inc    = (state == CMP);
  assign mis_inc    = cmp_inc && !match_now;

  sat_counter #(.W(CNT_W)) u_compare_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (cmp_inc),
    .count (compare_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mismatch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mis_inc),
    .count (mismatch_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      wait_cnt           <= '0;
      cmp_done           <= 1'b0;
      cmp_match          <= 1'b0;
      first_fail_valid   <= 1'b0;
      first_fail_golden  <= '0;
      first_fail_netlist <= '0;
      first_fail_index   <= '0;
      overrun            <= 1'b0;
      pass               <= 1'b1;
    end else begin
      cmp_done <= 1'b0;
      pass     <= (mismatch_cnt == '0) && !overrun;
      case (state)
        IDLE: begin
          if (stim_valid) begin
            // The sampling edge is E0+SETTLE, so a settle of one skips WAIT.
            state    <= (SETTLE_C == 1) ? CMP : WAIT;
            wait_cnt <= 8'(SETTLE_C - 1);
          end
        end
        WAIT: begin
          if (stim_valid) overrun <= 1'b1;
          if (wait_cnt <= 8'd1) state <= CMP;
          wait_cnt <= wait_cnt - 8'd1;
        end
        CMP: begin
          if (stim_valid) overrun <= 1'b1;
          cmp_done  <= 1'b1;
          cmp_match <= match_now;
          if (!match_now && !first_fail_valid) begin
            first_fail_valid   <= 1'b1;
            first_fail_golden  <= golden_out;
            first_fail_netlist <= netlist_out;
            first_fail_index   <= compare_cnt;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_compare_checker.sv
// Directed bench for out_compare_checker: a default-width instance plus a
// 4-bit-counter instance sharing the same stimulus for the saturation steps.
module tb_out_compare_checker;

  localparam int WIDTH  = 32;
  localparam int SETTLE = 2;
  localparam int CNT_W  = 16;
  localparam int SAT_W  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             stim_valid = 1'b0;
  logic [WIDTH-1:0] golden_out = '0;
  logic [WIDTH-1:0] netlist_out = '0;
  logic [WIDTH-1:0] cmp_mask = '1;

  logic             stim_ready, cmp_done, cmp_match, first_fail_valid, overrun, pass;
  logic [CNT_W-1:0] compare_cnt, mismatch_cnt, first_fail_index;
  logic [WIDTH-1:0] first_fail_golden, first_fail_netlist;
  logic [1:0]       dbg_state;

  logic             s_ready, s_done, s_match, s_ffv, s_overrun, s_pass;
  logic [SAT_W-1:0] s_cmp_cnt, s_mis_cnt, s_ffi;
  logic [WIDTH-1:0] s_ffg, s_ffn;
  logic [1:0]       s_state;

  int vectors = 0;
  int miscompares = 0;
  int sat_done_seen = 0;

  always #5 clk = ~clk;

  out_compare_checker #(.WIDTH(WIDTH), .SETTLE(SETTLE), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .stim_valid(stim_valid), .stim_ready(stim_ready),
    .golden_out(golden_out), .netlist_out(netlist_out), .cmp_mask(cmp_mask),
    .cmp_done(cmp_done), .cmp_match(cmp_match), .compare_cnt(compare_cnt),
    .mismatch_cnt(mismatch_cnt), .first_fail_valid(first_fail_valid),
    .first_fail_golden(first_fail_golden), .first_fail_netlist(first_fail_netlist),
    .first_fail_index(first_fail_index), .overrun(overrun), .pass(pass),
    .dbg_state(dbg_state)
  );

  out_compare_checker #(.WIDTH(WIDTH), .SETTLE(SETTLE), .CNT_W(SAT_W)) u_sat (
    .clk(clk), .rst(rst), .stim_valid(stim_valid), .stim_ready(s_ready),
    .golden_out(golden_out), .netlist_out(netlist_out), .cmp_mask(cmp_mask),
    .cmp_done(s_done), .cmp_match(s_match), .compare_cnt(s_cmp_cnt),
    .mismatch_cnt(s_mis_cnt), .first_fail_valid(s_ffv),
    .first_fail_golden(s_ffg), .first_fail_netlist(s_ffn),
    .first_fail_index(s_ffi), .overrun(s_overrun), .pass(s_pass),
    .dbg_state(s_state)
  );

  always @(negedge clk) begin
    if (!rst && s_done) sat_done_seen++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    stim_valid = 1'b0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  // Present one stimulus, hold the data until the result appears.
  // lat_o counts edges after the accepting edge until cmp_done is visible.
  task automatic do_compare(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] n,
                            input logic [WIDTH-1:0] m, output logic match_o,
                            output int lat_o);
    int guard;
    guard = 0;
    while (!stim_ready && guard < 50) begin
      step();
      guard++;
    end
    golden_out  = g;
    netlist_out = n;
    cmp_mask    = m;
    stim_valid  = 1'b1;
    step();
    stim_valid = 1'b0;
    lat_o = 0;
    while (!cmp_done && lat_o < 50) begin
      step();
      lat_o++;
    end
    if (!cmp_done) begin
      vectors++;
      miscompares++;
      $error("FAIL cmp_done_timeout: observed no pulse expected pulse within 50 cycles");
    end
    match_o = cmp_match;
  endtask

  initial begin
    logic m;
    int   lat;
    int   pulses;

    // Reset state
    reset_dut();
    check("rst_ready", stim_ready, 1);
    check("rst_compare_cnt", compare_cnt, 0);
    check("rst_mismatch_cnt", mismatch_cnt, 0);
    check("rst_pass", pass, 1);
    check("rst_ffv", first_fail_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_cmp_done", cmp_done, 0);

    // Equal data: ready drops while waiting, result at edge E0+SETTLE
    golden_out  = 32'hDEADBEEF;
    netlist_out = 32'hDEADBEEF;
    cmp_mask    = '1;
    stim_valid  = 1'b1;
    step();
    stim_valid = 1'b0;
    check("wait_ready_low", stim_ready, 0);
    check("wait_no_done", cmp_done, 0);
    step();
    check("wait2_no_done", cmp_done, 0);
    step();
    check("eq_done", cmp_done, 1);
    check("eq_ready_back", stim_ready, 1);
    check("eq_match", cmp_match, 1);
    check("eq_compare_cnt", compare_cnt, 1);
    check("eq_mismatch_cnt", mismatch_cnt, 0);
    step();
    check("eq_done_one_cycle", cmp_done, 0);
    do_compare(32'hDEADBEEF, 32'hDEADBEEF, '1, m, lat);
    check("eq_latency", lat, SETTLE);

    // First-failure capture over compares #0..#4
    reset_dut();
    do_compare(32'hA5A5_A5A5, 32'hA5A5_A5A5, '1, m, lat);
    check("ff_c0_match", m, 1);
    do_compare(32'h0000_1234, 32'h0000_1234, '1, m, lat);
    check("ff_c1_match", m, 1);
    do_compare(32'h0000_00F0, 32'h0000_00F1, '1, m, lat);
    check("ff_c2_match", m, 0);
    do_compare(32'h5555_0000, 32'h5555_0000, '1, m, lat);
    check("ff_c3_match", m, 1);
    do_compare(32'h0000_0001, 32'h0000_0002, '1, m, lat);
    check("ff_c4_match", m, 0);
    check("ff_compare_cnt", compare_cnt, 5);
    check("ff_mismatch_cnt", mismatch_cnt, 2);
    check("ff_valid", first_fail_valid, 1);
    check("ff_index", first_fail_index, 2);
    check("ff_golden", first_fail_golden, 32'hF0);
    check("ff_netlist", first_fail_netlist, 32'hF1);
    step();
    check("ff_pass_low", pass, 0);

    // Mask
    do_compare(32'hFFFF_0000, 32'hFFFF_0001, 32'hFFFF_FFFE, m, lat);
    check("mask_lsb_off", m, 1);
    do_compare(32'hFFFF_0000, 32'hFFFF_0001, 32'hFFFF_FFFF, m, lat);
    check("mask_all_on", m, 0);
    do_compare(32'h1234_5678, 32'h8765_4321, 32'h0, m, lat);
    check("mask_zero", m, 1);
    check("mask_mismatch_cnt", mismatch_cnt, 3);
    check("mask_ff_index_kept", first_fail_index, 2);

    // Overrun: second strobe one cycle after acceptance is ignored
    reset_dut();
    golden_out  = 32'h0BAD_CAFE;
    netlist_out = 32'h0BAD_CAFE;
    cmp_mask    = '1;
    stim_valid  = 1'b1;
    step();
    step();
    stim_valid = 1'b0;
    check("ovr_overrun", overrun, 1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (cmp_done) pulses++;
    end
    check("ovr_one_pulse", pulses, 1);
    check("ovr_compare_cnt", compare_cnt, 1);
    check("ovr_mismatch_cnt", mismatch_cnt, 0);
    check("ovr_pass", pass, 0);

    // Abort: reset while waiting
    stim_valid = 1'b1;
    step();
    stim_valid = 1'b0;
    check("abort_in_wait", stim_ready, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (cmp_done) pulses++;
      step();
    end
    check("abort_no_pulse", pulses, 0);
    check("abort_compare_cnt", compare_cnt, 0);
    check("abort_overrun", overrun, 0);
    check("abort_pass", pass, 1);

    // Saturation on the 4-bit-counter instance
    reset_dut();
    sat_done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      do_compare(32'(i + 16), ~32'(i + 16), '1, m, lat);
    end
    step();
    check("sat_done_pulses", sat_done_seen, 20);
    check("sat_compare_cnt", s_cmp_cnt, 15);
    check("sat_mismatch_cnt", s_mis_cnt, 15);
    check("sat_ff_index", s_ffi, 0);
    check("sat_ff_golden", s_ffg, 32'h10);
    check("sat_ready", s_ready, 1);
    check("wide_compare_cnt", compare_cnt, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish within 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
